// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - instruction prefetch queue with credit-limited issue and redirect flush
module ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        CLK,
  input  logic        RESET,
  output logic        IMEM_REQ,
  output logic [63:0] IMEM_ADDR,
  input  logic        IMEM_GNT,
  input  logic        IMEM_RVALID,
  input  logic [31:0] IMEM_RDATA,
  output logic        FE_V,
  output logic [31:0] FE_IR,
  output logic [63:0] FE_PC,
  output logic [63:0] FE_NPC,
  input  logic        FE_RDY,
  input  logic        REDIRECT,
  input  logic [63:0] REDIRECT_ADDR
);
  localparam int              AW         = $clog2(DEPTH);
  localparam int              CW         = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]   LP_ONE     = CW'(1);
  localparam logic [CW:0]     LP_DEPTH   = (CW + 1)'(DEPTH);
  localparam logic [AW-1:0]   LP_PTR_ONE = AW'(1);

  logic [63:0]   r_req_pc;
  logic [63:0]   r_resp_pc;
  logic [63:0]   r_pc_mem [DEPTH];
  logic [31:0]   r_ir_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_discard;

  logic [CW:0]   w_in_use;
  logic          w_credit;
  logic          w_accept;
  logic          w_drop;
  logic          w_push;
  logic          w_pop;
  logic          w_nonempty;
  logic [CW-1:0] w_out_after_rsp;
  logic [CW-1:0] w_out_next;
  logic [63:0]   w_redirect_pc;
  logic [63:0]   w_head_pc;

  // Buffered entries plus in-flight requests never exceed DEPTH, so a response always has a slot.
  assign w_in_use  = {1'b0, r_count} + {1'b0, r_outstanding};
  assign w_credit  = w_in_use < LP_DEPTH;
  assign IMEM_REQ  = RESET && w_credit && !REDIRECT;
  assign IMEM_ADDR = r_req_pc;
  assign w_accept  = IMEM_REQ && IMEM_GNT;

  assign w_out_after_rsp = IMEM_RVALID ? (r_outstanding - LP_ONE) : r_outstanding;
  assign w_out_next      = w_accept ? (w_out_after_rsp + LP_ONE) : w_out_after_rsp;

  // Responses belonging to requests issued before the last redirect are squashed.
  assign w_drop = IMEM_RVALID && (r_discard != '0);
  assign w_push = IMEM_RVALID && !w_drop && !REDIRECT;

  assign w_nonempty = r_count != '0;
  assign FE_V       = w_nonempty && !REDIRECT;
  assign w_pop      = FE_V && FE_RDY;

  assign w_redirect_pc = REDIRECT_ADDR & ~64'h3;
  assign w_head_pc     = r_pc_mem[r_rd_ptr];
  assign FE_PC         = w_nonempty ? w_head_pc : '0;
  assign FE_NPC        = w_nonempty ? (w_head_pc + 64'd4) : '0;
  assign FE_IR         = w_nonempty ? r_ir_mem[r_rd_ptr] : '0;

  // Control state: fetch addresses, pointers, occupancy and in-flight bookkeeping.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_req_pc      <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else if (REDIRECT) begin
      r_req_pc      <= w_redirect_pc;
      r_resp_pc     <= w_redirect_pc;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
      r_outstanding <= w_out_after_rsp;
      r_discard     <= w_out_after_rsp;
    end else begin
      r_outstanding <= w_out_next;
      if (w_accept) begin
        r_req_pc <= r_req_pc + 64'd4;
      end
      if (w_drop) begin
        r_discard <= r_discard - LP_ONE;
      end
      if (w_push) begin
        r_wr_ptr  <= r_wr_ptr + LP_PTR_ONE;
        r_resp_pc <= r_resp_pc + 64'd4;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + LP_PTR_ONE;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + LP_ONE;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - LP_ONE;
      end
    end
  end

  // Entry storage: write the returning instruction and its PC at the tail.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr] <= r_resp_pc;
      r_ir_mem[r_wr_ptr] <= IMEM_RDATA;
    end
  end
endmodule

// File: tb/tb_ifetch_queue.sv
// tb/tb_ifetch_queue.sv - self-checking bench for ifetch_queue
module tb_ifetch_queue;
  localparam int          DEPTH = 4;
  localparam logic [63:0] RPC   = 64'h1000;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        IMEM_REQ;
  logic [63:0] IMEM_ADDR;
  logic        IMEM_GNT;
  logic        IMEM_RVALID;
  logic [31:0] IMEM_RDATA;
  logic        FE_V;
  logic [31:0] FE_IR;
  logic [63:0] FE_PC;
  logic [63:0] FE_NPC;
  logic        FE_RDY;
  logic        REDIRECT;
  logic [63:0] REDIRECT_ADDR;

  ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .CLK(CLK), .RESET(RESET),
    .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR), .IMEM_GNT(IMEM_GNT),
    .IMEM_RVALID(IMEM_RVALID), .IMEM_RDATA(IMEM_RDATA),
    .FE_V(FE_V), .FE_IR(FE_IR), .FE_PC(FE_PC), .FE_NPC(FE_NPC), .FE_RDY(FE_RDY),
    .REDIRECT(REDIRECT), .REDIRECT_ADDR(REDIRECT_ADDR)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic [63:0] addr; int due; } mreq_t;
  typedef struct { logic [63:0] pc; logic [31:0] ir; } ent_t;
  typedef struct {
    bit gnt; bit rdy; bit redir; logic [63:0] raddr;
    bit e_req; logic [63:0] e_addr; bit e_fev; logic [63:0] e_pc;
  } vec_t;

  mreq_t       mem_q[$];
  ent_t        m_q[$];
  logic [63:0] acc_log[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          lat = 1;
  int          m_out, m_disc;
  logic [63:0] m_req_pc, m_resp_pc, exp_cons;
  bit          c_req, c_fev;
  logic [63:0] c_addr, c_pc, c_npc;
  logic [31:0] c_ir;
  bit          prev_stall;
  logic [63:0] prev_addr;
  vec_t        vt[10];

  function automatic logic [31:0] f(input logic [63:0] a);
    return (a[33:2] * 32'h9E3779B1) ^ a[63:32];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mem_q.delete(); m_q.delete(); acc_log.delete();
    m_out = 0; m_disc = 0;
    m_req_pc = RPC; m_resp_pc = RPC; exp_cons = RPC;
    prev_stall = 0;
  endtask

  task automatic do_reset();
    RESET = 1'b0; IMEM_GNT = 0; FE_RDY = 0; REDIRECT = 0; REDIRECT_ADDR = '0;
    IMEM_RVALID = 0; IMEM_RDATA = '0;
    model_reset();
    repeat (2) @(negedge CLK);
    chk("reset_req", IMEM_REQ, 0);
    chk("reset_fe_v", FE_V, 0);
    RESET = 1'b1;
  endtask

  // One clock: drive at negedge, compare with the reference model, advance model at posedge.
  task automatic step(input bit gnt, input bit rdy, input bit redir, input logic [63:0] raddr);
    bit e_req, e_fev;
    @(negedge CLK);
    IMEM_GNT = gnt; FE_RDY = rdy; REDIRECT = redir; REDIRECT_ADDR = raddr;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      IMEM_RVALID = 1; IMEM_RDATA = f(mem_q[0].addr);
    end else begin
      IMEM_RVALID = 0; IMEM_RDATA = $urandom;
    end
    #1;
    c_req = IMEM_REQ; c_addr = IMEM_ADDR; c_fev = FE_V; c_pc = FE_PC; c_ir = FE_IR; c_npc = FE_NPC;
    e_req = (m_q.size() + m_out < DEPTH) && !redir;
    e_fev = (m_q.size() != 0) && !redir;
    chk("imem_req", c_req, e_req);
    if (e_req && c_req) chk("imem_addr", c_addr, m_req_pc);
    chk("fe_v", c_fev, e_fev);
    if (e_fev && c_fev) begin
      chk("fe_pc", c_pc, m_q[0].pc);
      chk("fe_ir", c_ir, m_q[0].ir);
      chk("fe_npc", c_npc, m_q[0].pc + 64'd4);
    end
    if (prev_stall && c_req && !redir) chk("addr_hold", c_addr, prev_addr);
    prev_stall = c_req && !gnt;
    prev_addr  = c_addr;
    @(posedge CLK);
    if (IMEM_RVALID) void'(mem_q.pop_front());
    if (c_req && gnt) begin
      mem_q.push_back('{c_addr, cyc + lat});
      acc_log.push_back(c_addr);
    end
    if (c_fev && rdy) begin
      chk("consume_order", c_pc, exp_cons);
      exp_cons = exp_cons + 64'd4;
    end
    if (redir) begin
      m_out    = m_out - int'(IMEM_RVALID);
      m_disc   = m_out;
      m_q.delete();
      m_req_pc = raddr & ~64'h3; m_resp_pc = m_req_pc; exp_cons = m_req_pc;
    end else begin
      if (e_fev && rdy) void'(m_q.pop_front());
      if (e_req && gnt) begin m_req_pc = m_req_pc + 64'd4; m_out++; end
      if (IMEM_RVALID) begin
        m_out--;
        if (m_disc > 0) m_disc--;
        else begin
          m_q.push_back('{m_resp_pc, f(m_resp_pc)});
          m_resp_pc = m_resp_pc + 64'd4;
        end
      end
    end
    cyc++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_acc, k;
    for (int i = 0; i < 6; i++)
      vt[i] = '{1, 1, 0, 64'h0, 1, RPC + 64'(4 * i), (i >= 2), RPC + 64'(4 * (i - 2))};
    vt[6] = '{1, 1, 1, 64'h2002, 0, 64'h0,    0, 64'h0};
    vt[7] = '{1, 1, 0, 64'h0,    1, 64'h2000, 0, 64'h0};
    vt[8] = '{1, 1, 0, 64'h0,    1, 64'h2004, 0, 64'h0};
    vt[9] = '{1, 1, 0, 64'h0,    1, 64'h2008, 1, 64'h2000};

    do_reset();

    // Reset-and-stream, then redirect coinciding with a response and a consume.
    lat = 1;
    for (int i = 0; i < 10; i++) begin
      step(vt[i].gnt, vt[i].rdy, vt[i].redir, vt[i].raddr);
      chk("tbl_req", c_req, vt[i].e_req);
      if (vt[i].e_req) chk("tbl_addr", c_addr, vt[i].e_addr);
      chk("tbl_fe_v", c_fev, vt[i].e_fev);
      if (vt[i].e_fev) chk("tbl_fe_pc", c_pc, vt[i].e_pc);
    end

    // Backpressure: exactly DEPTH requests, then REQ drops; release resumes stream.
    step(1, 0, 1, 64'h3000);
    n_acc = 0;
    for (int i = 0; i < 20; i++) begin
      step(1, 0, 0, 64'h0);
      if (c_req) n_acc++;
    end
    chk("bp_requests", 64'(n_acc), 64'(DEPTH));
    chk("bp_req_low", c_req, 0);
    chk("bp_fe_v", c_fev, 1);
    chk("bp_head", c_pc, 64'h3000);
    for (int i = 0; i < 12; i++) step(1, 1, 0, 64'h0);

    // Redirect with three requests in flight at latency 3.
    lat = 3;
    for (int i = 0; i < 8; i++) step(1, 1, 0, 64'h0);
    k = 0;
    while (mem_q.size() != 3 && k < 20) begin step(1, 1, 0, 64'h0); k++; end
    chk("inflight_three", 64'(mem_q.size()), 64'd3);
    step(1, 1, 1, 64'h2002);
    k = 0;
    do begin step(1, 0, 0, 64'h0); k++; end while (!c_fev && k < 20);
    chk("redir_fe_v", c_fev, 1);
    chk("redir_fe_pc", c_pc, 64'h2000);
    chk("redir_fe_npc", c_npc, 64'h2004);
    for (int i = 0; i < 10; i++) step(1, 1, 0, 64'h0);

    // Address wrap under random grant stalls.
    lat = 1;
    step(1, 1, 1, 64'hFFFF_FFFF_FFFF_FFF8);
    acc_log.delete();
    for (int i = 0; i < 40; i++) step(bit'($urandom_range(0, 1)), 1, 0, 64'h0);
    if (acc_log.size() >= 4) begin
      chk("wrap_a0", acc_log[0], 64'hFFFF_FFFF_FFFF_FFF8);
      chk("wrap_a1", acc_log[1], 64'hFFFF_FFFF_FFFF_FFFC);
      chk("wrap_a2", acc_log[2], 64'h0);
      chk("wrap_a3", acc_log[3], 64'h4);
    end else begin
      chk("wrap_count", 64'(acc_log.size()), 64'd4);
    end

    // Randomized traffic against the reference model.
    for (int i = 0; i < 1500; i++) begin
      if (i % 100 == 0) lat = $urandom_range(1, 4);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 49) == 0, {$urandom, $urandom});
    end

    // Asynchronous reset between clock edges with a full queue.
    lat = 1;
    step(1, 0, 1, 64'h5000);
    for (int i = 0; i < 8; i++) step(1, 0, 0, 64'h0);
    chk("pre_reset_fe_v", c_fev, 1);
    #2 RESET = 1'b0;
    #1;
    chk("async_req", IMEM_REQ, 0);
    chk("async_fe_v", FE_V, 0);
    do_reset();
    k = 0;
    do begin step(1, 1, 0, 64'h0); k++; end while (!c_fev && k < 10);
    chk("restart_fe_v", c_fev, 1);
    chk("restart_pc", c_pc, RPC);
    for (int i = 0; i < 6; i++) step(1, 1, 0, 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ifetch_queue.md
# ifetch_queue

Instruction prefetch queue sitting directly upstream of the fetch stage. It issues in-order, word-aligned requests to the instruction memory and buffers up to DEPTH returned instructions with their PCs. It presents them to fetch through a valid/ready handshake. A writeback-stage redirect (taken branch or jump) flushes the queue, squashes in-flight responses and restarts prefetch at the target.

## Interface
- DEPTH, 4: queue entries; power of two, ≥2; also the cap on in-flight requests.
- RESET_PC, 64'h0: first fetch address after reset.
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  reset, asynchronous, active-low.
- IMEM_REQ  out  1  request valid.
- IMEM_ADDR  out  64  request address; bits [1:0] always 0.
- IMEM_GNT  in  1  memory accepts the request when IMEM_REQ && IMEM_GNT.
- IMEM_RVALID  in  1  response valid; responses come in request order, exactly one per accepted request, at least 1 cycle after acceptance.
- IMEM_RDATA  in  32  response instruction word.
- FE_V  out  1  head entry valid.
- FE_IR  out  32  head instruction.
- FE_PC  out  64  head PC.
- FE_NPC  out  64  FE_PC + 4, modulo 2^64.
- FE_RDY  in  1  fetch consumes the head when FE_V && FE_RDY; fetch holds FE_RDY low while stalled.
- REDIRECT  in  1  flush and restart; driven by OUT_FE_PC_MUX.
- REDIRECT_ADDR  in  64  restart address; bits [1:0] ignored and treated as 0.

## Operation
- **State:**
  - req_pc (next request address)
  - resp_pc (PC of next expected response)
  - queue of {pc, ir} with rd/wr pointers and count
  - outstanding counter (accepted, not yet returned)
  - discard counter
  - Counters are $clog2(DEPTH+1) bits.
- **Issue:**
  - IMEM_REQ = (count + outstanding < DEPTH) && !REDIRECT && RESET deasserted.
  - IMEM_ADDR = req_pc.
  - On acceptance: req_pc += 4 (wraps at 2^64), outstanding += 1.
- **Response:**
  - On IMEM_RVALID, outstanding −= 1.
  - If discard > 0: discard −= 1 and the data is dropped.
  - Otherwise {resp_pc, IMEM_RDATA} is written to the tail and resp_pc += 4.
  - The credit rule guarantees the queue never overflows. A response arriving while the queue is full is a protocol violation that cannot occur and needs no handling.
- **Dequeue:**
  - FE_V = count != 0 && !REDIRECT.
  - On FE_V && FE_RDY, the head is popped.
  - Push and pop in the same cycle leave count unchanged; both are legal at any fill level.
- **Redirect (priority over everything):**
  - Queue emptied (count = 0, pointers reset).
  - req_pc and resp_pc <= {REDIRECT_ADDR[63:2], 2'b00}.
  - discard <= outstanding_next, where outstanding_next = outstanding − RVALID. A response arriving in the redirect cycle is dropped.
  - No request is issued in the redirect cycle.
  - FE_V is forced 0, so no consume can occur.
- **Back-to-back redirects:** the later redirect wins. discard is recomputed from the then-current outstanding.
- **Reset (asynchronous, any time, including mid-transfer):**
  - req_pc = resp_pc = RESET_PC; count, outstanding and discard = 0.
  - IMEM_REQ = 0, FE_V = 0.
  - FE_IR, FE_PC and FE_NPC are don't-care while FE_V = 0; the implementation drives them to 0.
  - Responses for requests in flight at reset are the memory model's responsibility; the bench resets both together.

## Timing
- IMEM_REQ is combinational from registered state and REDIRECT. FE_* outputs come from registered queue state, gated only by REDIRECT on FE_V.
- First IMEM_REQ: the cycle after RESET deasserts, with IMEM_ADDR = RESET_PC.
- Fill latency: response in cycle t gives FE_V = 1 in cycle t+1.
- With 1-cycle memory and GNT tied high:
  - Redirect asserted in cycle r.
  - Request at target in r+1, response in r+2, FE_V in r+3.
- Sustained throughput: 1 instruction/cycle when memory latency ≤ DEPTH−1 and FE_RDY = 1.
- Stall: FE_RDY low fills the queue to DEPTH (counting outstanding requests), then IMEM_REQ drops. It reasserts the cycle after the first pop.

## Test plan
- **Reset and stream:**
  - Stimulus: RESET_PC = 0x1000, memory latency 1, GNT = 1, FE_RDY = 1.
  - Required: FE_PC = 0x1000, 0x1004, 0x1008, … on consecutive cycles from cycle 3; FE_NPC = FE_PC + 4; IR matches memory.
- **Backpressure:**
  - Stimulus: FE_RDY = 0 for 20 cycles, DEPTH = 4.
  - Required: exactly 4 requests issued, count = 4, IMEM_REQ = 0. On release, 4 pops then the stream continues with no PC gap or duplicate.
- **Redirect with in-flight requests:**
  - Stimulus: latency 3, redirect to 0x2002 with 3 outstanding.
  - Required: those 3 responses are dropped; the next FE_PC is 0x2000, FE_NPC = 0x2004; no stale instruction reaches fetch.
- **Simultaneous events:**
  - Stimulus: REDIRECT, IMEM_RVALID and FE_RDY all high in one cycle with a non-empty queue.
  - Required: FE_V = 0, no pop, response dropped, queue empty next cycle.
- **Grant stalls and wrap:**
  - Stimulus: random GNT, req_pc started at 0xFFFF_FFFF_FFFF_FFF8.
  - Required: addresses …FFF8, …FFFC, 0x0, 0x4 in order; IMEM_ADDR held stable while REQ && !GNT.
- **Asynchronous reset mid-stream:**
  - Stimulus: RESET low between clock edges with a full queue.
  - Required: FE_V and IMEM_REQ drop immediately; restart at RESET_PC after release.
